// File: rtl/bk_pulse_scheduler.sv
// Round-robin breakdown-test pulse scheduler: one fixed-width pulse per slot over the enabled channels.
// Optional define BK_SCHED_PULSE_CNT_EN adds a wrapping 16-bit count of issued pulses on o_pulse_cnt.
module bk_pulse_scheduler #(
  parameter int N_CH      = 6,
  parameter int PULSE_CYC = 875,
  parameter int SLOT_CYC  = 500000,
  parameter int CNT_W     = 19
) (
  input  logic            i_clk_25m,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_single,
  input  logic [N_CH-1:0] i_ch_mask,
  output logic [N_CH-1:0] o_bk_pulse,
  output logic [2:0]      o_ch_idx,
  output logic            o_busy,
  output logic            o_sweep_done
`ifdef BK_SCHED_PULSE_CNT_EN
  ,
  output logic [15:0]     o_pulse_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [N_CH-1:0]  r_mask, w_mask, w_hiMask, r_pulse, w_pulse;
  logic [2:0]       r_ch, w_ch;
  logic             r_busy, r_done, w_done, w_entry;

  function automatic logic [2:0] lowBit(input logic [N_CH-1:0] m);
    lowBit = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i]) lowBit = 3'(i);
  endfunction

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_mask   = r_mask;
    w_ch     = r_ch;
    w_done   = 1'b0;
    w_hiMask = '0;
    for (int i = 0; i < N_CH; i++)
      w_hiMask[i] = r_mask[i] && (i > int'(r_ch));

    if (i_stop) begin
      w_state = IDLE;
      w_cnt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt = '0;
          if (i_start && (|i_ch_mask)) begin
            w_mask  = i_ch_mask;
            w_ch    = lowBit(i_ch_mask);
            w_state = PULSE;
          end
        end
        PULSE: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(PULSE_CYC - 1)) w_state = GAP;
        end
        GAP: begin
          if (r_cnt == CNT_W'(SLOT_CYC - 1)) begin
            w_cnt = '0;
            if (|w_hiMask) begin
              w_ch    = lowBit(w_hiMask);
              w_state = PULSE;
            end else begin
              // Sweep boundary: the only point where a new mask is taken in
              w_done = 1'b1;
              if (i_single) begin
                w_state = IDLE;
              end else begin
                w_mask = i_ch_mask;
                if (|i_ch_mask) begin
                  w_ch    = lowBit(i_ch_mask);
                  w_state = PULSE;
                end else begin
                  w_state = IDLE;
                end
              end
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state = IDLE;
          w_cnt   = '0;
        end
      endcase
    end

    w_pulse = '0;
    if (w_state == PULSE) w_pulse = {{(N_CH-1){1'b0}}, 1'b1} << w_ch;
    w_entry = (w_state == PULSE) && (r_state != PULSE);
  end

  always_ff @(posedge i_clk_25m) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_ch    <= '0;
      r_pulse <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_mask  <= w_mask;
      r_ch    <= w_ch;
      r_pulse <= w_pulse;
      r_busy  <= (w_state != IDLE);
      r_done  <= w_done;
    end
  end

  assign o_bk_pulse   = r_pulse;
  assign o_ch_idx     = r_ch;
  assign o_busy       = r_busy;
  assign o_sweep_done = r_done;

`ifdef BK_SCHED_PULSE_CNT_EN
  logic [15:0] r_pulseCnt;

  always_ff @(posedge i_clk_25m) begin
    if (i_rst) r_pulseCnt <= '0;
    else if (w_entry) r_pulseCnt <= r_pulseCnt + 16'd1;
  end

  assign o_pulse_cnt = r_pulseCnt;
`else
  logic w_unusedEntry;
  assign w_unusedEntry = w_entry;
`endif

endmodule
